uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_cfg.sv | 158 +++++++++++++++
 tb/tb_uart_rx_cfg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: receive FSM states
// and the parity mode encodings used by the PARITY parameter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held at phase 0
// while clear is high so the first tick lands DIV clocks after clear drops.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick = !clear && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear || tick)
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with 2-of-3 majority bit decisions,
// optional odd/even parity, 1 or 2 stop bits and break handling.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] IDX_A   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] IDX_B   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] IDX_C   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] IDX_END = SW'(OVERSAMPLE - 1);

   if (DIV_RAW < 1 || OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
       DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PAR_NONE || PARITY > PAR_EVEN ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $fatal(1, "uart_rx_cfg: illegal parameter combination");
   end

   rx_state_t state, state_next;

   logic                 rx_meta, rx_sync, rx_prev;
   logic                 tick;
   logic [SW-1:0]        sample_cnt;
   logic [1:0]           ones;
   logic [1:0]           votes;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_acc;
   logic                 stop_err;
   logic                 sample_now, decide, bit_end, maj, last_stop;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state == ST_IDLE),
      .tick  (tick)
   );

   assign sample_now = tick && (sample_cnt == IDX_A || sample_cnt == IDX_B);
   assign decide     = tick && (sample_cnt == IDX_C);
   assign bit_end    = tick && (sample_cnt == IDX_END);
   assign votes      = ones + {1'b0, rx_sync};
   assign maj        = votes[1];
   assign last_stop  = (state == ST_STOP) && decide && (bit_cnt == 4'(STOP_BITS - 1));
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // The last stop bit leaves at its majority decision rather than at bit end,
   // which gives half a bit of slack for a following start edge.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:
            if (rx_prev && !rx_sync) state_next = ST_START;
         ST_START:
            if (decide && maj)  state_next = ST_IDLE;
            else if (bit_end)   state_next = ST_DATA;
         ST_DATA:
            if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
               state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY:
            if (bit_end) state_next = ST_STOP;
         ST_STOP:
            if (last_stop) state_next = (stop_err || !maj) ? ST_WAIT_IDLE : ST_IDLE;
         ST_WAIT_IDLE:
            if (rx_sync) state_next = ST_IDLE;
         default:
            state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         sample_cnt <= '0;
         ones       <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_acc    <= 1'b0;
         stop_err   <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         valid   <= 1'b0;

         if (state == ST_IDLE || bit_end)
            sample_cnt <= '0;
         else if (tick)
            sample_cnt <= sample_cnt + SW'(1);

         if (state == ST_IDLE || decide)
            ones <= '0;
         else if (sample_now)
            ones <= votes;

         if (state_next != state)
            bit_cnt <= '0;
         else if (bit_end)
            bit_cnt <= bit_cnt + 4'd1;

         if (state == ST_IDLE) begin
            par_acc  <= 1'b0;
            stop_err <= 1'b0;
         end else if (decide) begin
            if (state == ST_DATA)
               shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            if (state == ST_DATA || state == ST_PARITY)
               par_acc <= par_acc ^ maj;
            if (state == ST_STOP)
               stop_err <= stop_err | !maj;
         end

         if (last_stop) begin
            valid     <= 1'b1;
            data      <= shift_reg;
            frame_err <= stop_err | !maj;
            if (PARITY == PAR_ODD)
               parity_err <= !par_acc;
            else if (PARITY == PAR_EVEN)
               parity_err <= par_acc;
            else
               parity_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) driven
// from a directed vector table plus hand-written corner-case sequences.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam real CLK_P = 10.0;
   localparam real BIT_P = 160.0;

   logic clk;
   logic rst;
   logic rx [3];

   logic [7:0] data_a, data_b;
   logic [6:0] data_c;
   logic valid_a, valid_b, valid_c;
   logic perr_a, perr_b, perr_c;
   logic ferr_a, ferr_b, ferr_c;
   logic busy_a, busy_b, busy_c;

   int checks = 0;
   int errors = 0;

   int          vcount [3];
   logic [8:0]  last_data [3];
   logic        last_perr [3];
   logic        last_ferr [3];
   realtime     last_vtime [3];
   logic [8:0]  log_c [8];

   typedef struct {
      int         cfg;
      logic [8:0] word;
      logic       par_bit;
      logic       stop_val;
      logic [8:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [10];

   uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .uart_rx(rx[0]), .data(data_a), .valid(valid_a),
      .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

   uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_b (
      .clk(clk), .rst(rst), .uart_rx(rx[1]), .data(data_b), .valid(valid_b),
      .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

   uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                 .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_c (
      .clk(clk), .rst(rst), .uart_rx(rx[2]), .data(data_c), .valid(valid_c),
      .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Valid is a one-cycle registered pulse, so the falling edge always sees it.
   always @(negedge clk) begin
      if (valid_a) begin
         last_data[0] = {1'b0, data_a}; last_perr[0] = perr_a; last_ferr[0] = ferr_a;
         last_vtime[0] = $realtime; vcount[0] = vcount[0] + 1;
      end
      if (valid_b) begin
         last_data[1] = {1'b0, data_b}; last_perr[1] = perr_b; last_ferr[1] = ferr_b;
         last_vtime[1] = $realtime; vcount[1] = vcount[1] + 1;
      end
      if (valid_c) begin
         last_data[2] = {2'b0, data_c}; last_perr[2] = perr_c; last_ferr[2] = ferr_c;
         last_vtime[2] = $realtime; log_c[vcount[2] % 8] = {2'b0, data_c};
         vcount[2] = vcount[2] + 1;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic idle_bits(input int n);
      repeat (n * 16) @(negedge clk);
      #1;
   endtask

   task automatic send_frame(input int cfg, input logic [8:0] word, input logic par_bit,
                             input logic stop_val, input real bit_ns);
      int nb;
      int nstop;
      nb    = (cfg == 2) ? 7 : 8;
      nstop = (cfg == 2) ? 2 : 1;
      rx[cfg] = 1'b0;
      #(bit_ns);
      for (int i = 0; i < nb; i++) begin
         rx[cfg] = word[i];
         #(bit_ns);
      end
      if (cfg == 1) begin
         rx[cfg] = par_bit;
         #(bit_ns);
      end
      for (int i = 0; i < nstop; i++) begin
         rx[cfg] = stop_val;
         #(bit_ns);
      end
      rx[cfg] = 1'b1;
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      int      base;
      realtime t0;
      real     lat, exp_lat;
      int      total_bits;
      @(negedge clk);
      base = vcount[v.cfg];
      t0   = $realtime;
      send_frame(v.cfg, v.word, v.par_bit, v.stop_val, BIT_P);
      idle_bits(2);
      check_output($sformatf("vec%0d valid_count", idx), vcount[v.cfg] - base, 1);
      check_output($sformatf("vec%0d data", idx), {23'b0, last_data[v.cfg]}, {23'b0, v.exp_data});
      check_output($sformatf("vec%0d parity_err", idx), {31'b0, last_perr[v.cfg]}, {31'b0, v.exp_perr});
      check_output($sformatf("vec%0d frame_err", idx), {31'b0, last_ferr[v.cfg]}, {31'b0, v.exp_ferr});
      total_bits = 1 + ((v.cfg == 2) ? 7 : 8) + ((v.cfg == 1) ? 1 : 0) + ((v.cfg == 2) ? 2 : 1);
      exp_lat = real'((total_bits - 1) * 16 + 9 + 3);
      lat = (last_vtime[v.cfg] - CLK_P / 2.0 - t0) / CLK_P;
      checks++;
      if (lat < exp_lat - 1.0 || lat > exp_lat + 1.0) begin
         errors++;
         $display("[TB] FAIL vec%0d latency: got %0.1f clocks, expected %0.1f +/- 1", idx, lat, exp_lat);
      end
   endtask

   initial begin
      int base;
      for (int i = 0; i < 3; i++) begin
         rx[i] = 1'b1; vcount[i] = 0; last_data[i] = '0;
         last_perr[i] = 1'b0; last_ferr[i] = 1'b0; last_vtime[i] = 0.0;
      end
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check_output("reset data", {24'b0, data_a}, 0);
      check_output("reset valid", {31'b0, valid_a}, 0);
      check_output("reset busy", {31'b0, busy_a}, 0);
      check_output("reset frame_err", {31'b0, ferr_a}, 0);
      check_output("reset parity_err", {31'b0, perr_b}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_bits(2);

      vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
      vecs[1] = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
      vecs[2] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
      vecs[3] = '{0, 9'h0C3, 1'b0, 1'b0, 9'h0C3, 1'b0, 1'b1};
      vecs[4] = '{1, 9'h003, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};
      vecs[5] = '{1, 9'h003, 1'b0, 1'b1, 9'h003, 1'b0, 1'b0};
      vecs[6] = '{1, 9'h001, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0};
      vecs[7] = '{1, 9'h001, 1'b0, 1'b1, 9'h001, 1'b1, 1'b0};
      vecs[8] = '{1, 9'h080, 1'b1, 1'b0, 9'h080, 1'b0, 1'b1};
      vecs[9] = '{2, 9'h055, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++)
         apply_stimulus(vecs[i], i);

      // A 5-clock glitch is accepted as a start, then rejected at mid-bit.
      @(negedge clk);
      base = vcount[0];
      rx[0] = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check_output("glitch busy_high", {31'b0, busy_a}, 1);
      rx[0] = 1'b1;
      idle_bits(2);
      check_output("glitch no_valid", vcount[0] - base, 0);
      check_output("glitch busy_low", {31'b0, busy_a}, 0);
      apply_stimulus('{0, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0}, 10);

      // Break: one errored frame, then silence until the line has gone high.
      @(negedge clk);
      base = vcount[0];
      rx[0] = 1'b0;
      #(BIT_P * 20.0);
      check_output("break valid_count", vcount[0] - base, 1);
      check_output("break data", {23'b0, last_data[0]}, 0);
      check_output("break frame_err", {31'b0, last_ferr[0]}, 1);
      check_output("break busy_waiting", {31'b0, busy_a}, 1);
      rx[0] = 1'b1;
      idle_bits(3);
      check_output("break no_retrigger", vcount[0] - base, 1);
      check_output("break busy_low", {31'b0, busy_a}, 0);
      apply_stimulus('{0, 9'h033, 1'b0, 1'b1, 9'h033, 1'b0, 1'b0}, 11);

      // Back-to-back 7N2 frames, first 3% fast, second 3% slow.
      @(negedge clk);
      base = vcount[2];
      send_frame(2, 9'h011, 1'b0, 1'b1, BIT_P * 0.97);
      send_frame(2, 9'h07F, 1'b0, 1'b1, BIT_P * 1.03);
      idle_bits(2);
      check_output("b2b valid_count", vcount[2] - base, 2);
      check_output("b2b first_data", {23'b0, log_c[base % 8]}, 32'h11);
      check_output("b2b second_data", {23'b0, log_c[(base + 1) % 8]}, 32'h7F);
      check_output("b2b frame_err", {31'b0, last_ferr[2]}, 0);
      check_output("b2b parity_err", {31'b0, last_perr[2]}, 0);

      // Reset in the middle of 0xFF clears outputs at once and loses the frame.
      @(negedge clk);
      base = vcount[0];
      rx[0] = 1'b0;
      #(BIT_P);
      rx[0] = 1'b1;
      #(BIT_P * 3.0 + 3.0);
      rst = 1'b1;
      #1;
      check_output("midrst data", {24'b0, data_a}, 0);
      check_output("midrst valid", {31'b0, valid_a}, 0);
      check_output("midrst busy", {31'b0, busy_a}, 0);
      check_output("midrst frame_err", {31'b0, ferr_a}, 0);
      #30 rst = 1'b0;
      idle_bits(12);
      check_output("midrst no_valid", vcount[0] - base, 0);
      apply_stimulus('{0, 9'h081, 1'b0, 1'b1, 9'h081, 1'b0, 1'b0}, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
